// File: rtl/rca_wide_add_seq.sv
// ---------------------------------------------------------------------------
// rca_wide_add_seq
//
// Wide add/subtract sequencer. Two operands of WORDS*16 bits are combined
// through a single 16-bit ripple-carry slice, one word per clock, least
// significant word first. The inter-word carry lives in a register, so the
// slice is reused for every word of the operation.
//
// Parameters
//   WORDS   number of 16-bit words per operand (>= 1); N = 16*WORDS
//
// Ports
//   clk     in   1  clock, all state changes on the rising edge
//   rst_n   in   1  synchronous active-low reset
//   start   in   1  request an operation; only sampled while idle
//   sub     in   1  0: a+b, 1: a-b (sampled with start)
//   a       in   N  operand A (sampled with start)
//   b       in   N  operand B (sampled with start)
//   busy    out  1  operation in progress, start is ignored
//   done    out  1  one-cycle pulse, result/cout/ovf valid
//   result  out  N  registered sum or difference
//   cout    out  1  carry out of bit N-1 (subtract: 1 = no borrow)
//   ovf     out  1  two's-complement overflow of the N-bit operation
// ---------------------------------------------------------------------------
module rca_wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_carry;
    logic [WORDS-1:0][15:0]   r_opa;
    logic [WORDS-1:0][15:0]   r_opb;
    logic [WORDS-1:0][15:0]   r_result;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_cout;
    logic                     r_ovf;

    logic                     w_accept;
    logic [15:0]              w_a;
    logic [15:0]              w_b;
    logic [15:0]              w_sum;
    logic [16:0]              w_c;
    logic                     w_ovf;

    assign w_accept = (r_state == S_IDLE) && start;

    // Word currently presented to the slice.
    assign w_a = r_opa[r_idx];
    assign w_b = r_opb[r_idx];

    // 16-cell ripple-carry slice; carry-in comes from the inter-word register.
    assign w_c[0] = r_carry;
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
        assign w_sum[gi]  = w_a[gi] ^ w_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (w_a[gi] & w_b[gi]) | (w_c[gi] & (w_a[gi] ^ w_b[gi]));
    end

    // Only meaningful on the top word: opb already holds ~b for subtraction,
    // so the ordinary addition overflow rule covers both operations.
    assign w_ovf = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);

    // Operand capture. These are pure data registers: they are only consumed
    // while RUN, and RUN can only be entered through an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opa <= a;
            r_opb <= sub ? ~b : b;
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 enters as carry-in.
                        r_carry  <= sub;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= w_sum;
                    r_carry         <= w_c[16];
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_c[16];
                        r_ovf   <= w_ovf;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_rca_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_rca_wide_add_seq
//
// Bench for rca_wide_add_seq with a 4-word and a 1-word instance. Expected
// results (value, carry, overflow and the cycle in which done must appear)
// are queued when an operation is launched and retired when done is seen.
// ---------------------------------------------------------------------------
module tb_rca_wide_add_seq;

    typedef struct {
        logic [63:0] res;
        logic        co;
        logic        ov;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start4, sub4;
    logic [63:0] a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [63:0] result4;

    logic        start1, sub1;
    logic [15:0] a1, b1;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] result1;

    exp_t q4[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;
    int n_done4  = 0;

    rca_wide_add_seq #(.WORDS(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .sub    (sub4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .result (result4),
        .cout   (cout4),
        .ovf    (ovf4)
    );

    rca_wide_add_seq #(.WORDS(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .sub    (sub1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .result (result1),
        .cout   (cout1),
        .ovf    (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model64(input logic [63:0] a, input logic [63:0] b,
                                     input logic s, input int due);
        exp_t        e;
        logic [63:0] bb;
        logic [64:0] sum;
        bb    = s ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + 65'(s);
        e.res = sum[63:0];
        e.co  = sum[64];
        e.ov  = (a[63] == bb[63]) && (sum[63] != a[63]);
        e.due = due;
        return e;
    endfunction

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                     input logic s, input int due);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] sum;
        bb    = s ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + 17'(s);
        e.res = {48'h0, sum[15:0]};
        e.co  = sum[16];
        e.ov  = (a[15] == bb[15]) && (sum[15] != a[15]);
        e.due = due;
        return e;
    endfunction

    // Output monitor: retire one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (done4 === 1'b1) begin
            n_done4++;
            if (q4.size() == 0) begin
                check_eq("done4_unexpected", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check_eq("res4", result4, e.res);
                check_eq("cout4", {63'h0, cout4}, {63'h0, e.co});
                check_eq("ovf4", {63'h0, ovf4}, {63'h0, e.ov});
                check_eq("lat4", 64'(ncyc), 64'(e.due));
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check_eq("done1_unexpected", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check_eq("res1", {48'h0, result1}, e.res);
                check_eq("cout1", {63'h0, cout1}, {63'h0, e.co});
                check_eq("ovf1", {63'h0, ovf1}, {63'h0, e.ov});
                check_eq("lat1", 64'(ncyc), 64'(e.due));
            end
        end
    end

    // Call just after a rising edge; start is taken at the following edge.
    task automatic drive4(input logic [63:0] a, input logic [63:0] b, input logic s);
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        q4.push_back(model64(a, b, s, ncyc + 2 + 4));
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; sub4 = ~s;
    endtask

    task automatic drive1(input logic [15:0] a, input logic [15:0] b, input logic s);
        a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
        q1.push_back(model16(a, b, s, ncyc + 2 + 1));
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = 16'($urandom); b1 = 16'($urandom); sub1 = ~s;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check_eq(tag, 64'(q4.size() + q1.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   found;
        int   d0;
        logic s;

        rst_n = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        // start held high during reset must be dropped
        repeat (2) @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", {63'h0, busy4}, 64'd0);
        check_eq("rst_done", {63'h0, done4}, 64'd0);
        check_eq("rst_result", result4, 64'd0);
        check_eq("rst_cout", {63'h0, cout4}, 64'd0);
        check_eq("rst_ovf", {63'h0, ovf4}, 64'd0);
        check_eq("rst_busy1", {63'h0, busy1}, 64'd0);

        // Carry across a word boundary; also look inside the RUN window.
        @(posedge clk); #1;
        drive4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        @(negedge clk);
        check_eq("run_busy", {63'h0, busy4}, 64'd1);
        check_eq("run_result_zero", result4, 64'd0);
        drain("drain_a");
        repeat (3) @(negedge clk);
        check_eq("hold_result", result4, 64'h0000_0000_0001_0000);
        check_eq("idle_busy", {63'h0, busy4}, 64'd0);

        // Spec vectors.
        @(posedge clk); #1;
        drive4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        drain("drain_b");
        @(posedge clk); #1;
        drive4(64'd5, 64'd7, 1'b1);
        drain("drain_c");

        // Random mix of add and subtract.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            s = 1'($urandom);
            drive4({$urandom, $urandom}, {$urandom, $urandom}, s);
            drain("drain_rand4");
        end

        // start in RUN cycle 2 is ignored; start in the done cycle is accepted.
        @(posedge clk); #1;
        drive4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        @(posedge clk); #1;
        a4 = 64'hDEAD_BEEF_DEAD_BEEF; b4 = 64'h1111_2222_3333_4444; sub4 = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin
                found = 1;
                break;
            end
        end
        check_eq("done_seen", 64'(found), 64'd1);
        drive4(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0009, 1'b1);
        drain("drain_b2b");

        // Signed overflow on subtraction, leaves cout=1/ovf=1 before reset test.
        @(posedge clk); #1;
        drive4(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        drain("drain_ovf");

        // Reset in the middle of RUN aborts the operation.
        @(posedge clk); #1;
        drive4(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q4.delete();
        d0 = n_done4;
        @(negedge clk);
        check_eq("abort_busy", {63'h0, busy4}, 64'd0);
        check_eq("abort_done", {63'h0, done4}, 64'd0);
        check_eq("abort_result", result4, 64'd0);
        check_eq("abort_cout", {63'h0, cout4}, 64'd0);
        check_eq("abort_ovf", {63'h0, ovf4}, 64'd0);
        repeat (8) @(negedge clk);
        check_eq("abort_no_done", 64'(n_done4 - d0), 64'd0);

        // Operation after the abort still works.
        @(posedge clk); #1;
        drive4(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
        drain("drain_post_abort");

        // Single-word instance.
        @(posedge clk); #1;
        drive1(16'h7FFF, 16'h0001, 1'b0);
        drain("drain_w1_a");
        @(posedge clk); #1;
        drive1(16'h8000, 16'h0001, 1'b1);
        drain("drain_w1_b");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s = 1'($urandom);
            drive1(16'($urandom), 16'($urandom), s);
        end
        drain("drain_w1_rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
